// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the GCD requester: the requester FSM state
// encoding and the default operand width and WAIT timeout.
package gcd_pkg;

    localparam int GCD_WIDTH          = 16;
    localparam int GCD_TIMEOUT_CYCLES = 70000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_B,
        WAIT,
        RELEASE,
        RESP
    } state_t;

endpackage

// File: rtl/gcd_requester.sv
// gcd_requester
// Accepts one GCD job at a time over a valid/ready request port. Jobs
// with a zero operand are answered directly. All other jobs go to an
// external GCD engine: A and then B are sent over gcd_data, and the
// block waits for gcd_done, up to a bounded number of cycles. It then
// pulses gcd_restart and holds the response until the consumer takes it.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    job request valid
//   req_ready    block can accept a job (high only in IDLE)
//   req_a/req_b  operands, registered on acceptance
//   rsp_valid    result valid (high only in RESP)
//   rsp_ready    consumer accepts the result
//   rsp_gcd      result
//   rsp_err      both operands zero, or engine timeout
//   gcd_start    one-cycle start pulse to the engine
//   gcd_data     engine operand bus (A in START, B in LOAD_B, else 0)
//   gcd_done     engine result ready (level, sticky until restart)
//   gcd_result   engine result, valid while gcd_done is high
//   gcd_restart  one-cycle pulse returning the engine to idle
//   jobs_done    count of completed responses, wraps at 2^16
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH          = GCD_WIDTH,
    parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_err,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             gcd_restart,
    output logic [15:0]      jobs_done
);

    // A timeout of one cycle would give a zero-width counter; keep one bit.
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             a_zero;
    logic             b_zero;
    logic             timeout_hit;

    assign accept      = req_valid && req_ready;
    assign a_zero      = (req_a == '0);
    assign b_zero      = (req_b == '0);
    // gcd_done takes priority over the timeout in the same cycle.
    assign timeout_hit = (state == WAIT) && !gcd_done && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        gcd_start   = 1'b0;
        gcd_restart = 1'b0;
        gcd_data    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_next = (a_zero || b_zero) ? RESP : START;
                end
            end
            START: begin
                gcd_start  = 1'b1;
                gcd_data   = op_a;
                state_next = LOAD_B;
            end
            LOAD_B: begin
                gcd_data   = op_b;
                state_next = WAIT;
            end
            WAIT: begin
                if (gcd_done || timeout_hit) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                gcd_restart = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, WAIT counter, response register and job counter.
    // Zero-operand jobs have their response decided at acceptance; engine
    // jobs have it decided when WAIT ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            wait_cnt  <= '0;
            rsp_gcd   <= '0;
            rsp_err   <= 1'b0;
            jobs_done <= '0;
        end else begin
            if (accept) begin
                op_a <= req_a;
                op_b <= req_b;
                if (a_zero && b_zero) begin
                    rsp_gcd <= '0;
                    rsp_err <= 1'b1;
                end else if (a_zero) begin
                    rsp_gcd <= req_b;
                    rsp_err <= 1'b0;
                end else if (b_zero) begin
                    rsp_gcd <= req_a;
                    rsp_err <= 1'b0;
                end
            end

            // Cleared on the way into WAIT so the first WAIT cycle sees 0.
            if (state == LOAD_B) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == WAIT) begin
                if (gcd_done) begin
                    rsp_gcd <= gcd_result;
                    rsp_err <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_gcd <= '0;
                    rsp_err <= 1'b1;
                end
            end

            if ((state == RESP) && rsp_ready) begin
                jobs_done <= jobs_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester
// Directed bench for gcd_requester with a small behavioural GCD engine.
// The DUT is built with an 8-cycle timeout so the timeout path runs quickly.
module tb_gcd_requester;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic         gcd_start;
    logic [W-1:0] gcd_data;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         gcd_restart;
    logic [15:0]  jobs_done;

    int test_count;
    int fail_count;

    // Engine model state
    int           eng_phase;
    int           eng_delay;
    int           eng_latency;
    bit           eng_alive;
    logic [W-1:0] eng_a;
    logic [W-1:0] eng_b;
    int           start_count;
    int           restart_count;
    int           s0;
    int           r0;

    gcd_requester #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_gcd     (rsp_gcd),
        .rsp_err     (rsp_err),
        .gcd_start   (gcd_start),
        .gcd_data    (gcd_data),
        .gcd_done    (gcd_done),
        .gcd_result  (gcd_result),
        .gcd_restart (gcd_restart),
        .jobs_done   (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] euclid(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine: takes A with gcd_start, B on the next cycle, then raises a
    // sticky done eng_latency cycles later (never, if eng_alive is 0).
    always @(negedge clk) begin
        if (!rst_n) begin
            gcd_done   = 1'b0;
            gcd_result = '0;
            eng_phase  = 0;
        end else begin
            if (gcd_start)   start_count++;
            if (gcd_restart) restart_count++;
            if (gcd_restart) begin
                gcd_done  = 1'b0;
                eng_phase = 0;
            end else if (gcd_start) begin
                eng_a     = gcd_data;
                eng_phase = 1;
            end else if (eng_phase == 1) begin
                eng_b     = gcd_data;
                eng_phase = 2;
                eng_delay = eng_latency;
            end else if (eng_phase == 2) begin
                if (eng_delay == 0) begin
                    if (eng_alive) begin
                        gcd_done   = 1'b1;
                        gcd_result = euclid(eng_a, eng_b);
                    end
                    eng_phase = 3;
                end else begin
                    eng_delay--;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents a request for one cycle; returns at the negedge after the
    // accept edge (first cycle after accept).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic takeResponse();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_count    = 0;
        fail_count    = 0;
        start_count   = 0;
        restart_count = 0;
        eng_latency   = 0;
        eng_alive     = 1'b1;
        eng_phase     = 0;
        eng_delay     = 0;
        req_valid     = 1'b0;
        req_a         = '0;
        req_b         = '0;
        rsp_ready     = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        #1;
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_gcd_start", gcd_start, 0);
        checkOutput("reset_gcd_restart", gcd_restart, 0);
        checkOutput("reset_gcd_data", gcd_data, 0);
        checkOutput("reset_jobs_done", jobs_done, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // (48,18) through the engine
        s0 = start_count;
        r0 = restart_count;
        applyStimulus(16'd48, 16'd18);
        checkOutput("j1_start", gcd_start, 1);
        checkOutput("j1_data_a", gcd_data, 48);
        checkOutput("j1_req_ready", req_ready, 0);
        step(1);
        checkOutput("j1_start_off", gcd_start, 0);
        checkOutput("j1_data_b", gcd_data, 18);
        step(1);
        checkOutput("j1_wait_data", gcd_data, 0);
        checkOutput("j1_wait_valid", rsp_valid, 0);
        step(1);
        checkOutput("j1_restart", gcd_restart, 1);
        checkOutput("j1_release_valid", rsp_valid, 0);
        step(1);
        checkOutput("j1_valid", rsp_valid, 1);
        checkOutput("j1_gcd", rsp_gcd, 6);
        checkOutput("j1_err", rsp_err, 0);
        checkOutput("j1_restart_off", gcd_restart, 0);
        takeResponse();
        checkOutput("j1_valid_off", rsp_valid, 0);
        checkOutput("j1_req_ready_back", req_ready, 1);
        checkOutput("j1_jobs", jobs_done, 1);
        checkOutput("j1_start_pulses", start_count - s0, 1);
        checkOutput("j1_restart_pulses", restart_count - r0, 1);

        // rsp_ready while idle must not count a job
        rsp_ready = 1'b1;
        step(2);
        rsp_ready = 1'b0;
        checkOutput("idle_ready_jobs", jobs_done, 1);
        checkOutput("idle_ready_valid", rsp_valid, 0);

        // (0,7): direct answer, engine untouched
        s0 = start_count;
        r0 = restart_count;
        applyStimulus(16'd0, 16'd7);
        checkOutput("z1_valid", rsp_valid, 1);
        checkOutput("z1_gcd", rsp_gcd, 7);
        checkOutput("z1_err", rsp_err, 0);
        checkOutput("z1_start", gcd_start, 0);
        checkOutput("z1_data", gcd_data, 0);
        takeResponse();
        checkOutput("z1_jobs", jobs_done, 2);

        // (0,0): error, engine untouched
        applyStimulus(16'd0, 16'd0);
        checkOutput("z2_valid", rsp_valid, 1);
        checkOutput("z2_gcd", rsp_gcd, 0);
        checkOutput("z2_err", rsp_err, 1);
        checkOutput("z2_start", gcd_start, 0);
        takeResponse();
        checkOutput("z2_jobs", jobs_done, 3);

        // (12,0): nonzero operand on the A side
        applyStimulus(16'd12, 16'd0);
        checkOutput("z3_valid", rsp_valid, 1);
        checkOutput("z3_gcd", rsp_gcd, 12);
        checkOutput("z3_err", rsp_err, 0);
        takeResponse();
        checkOutput("z3_jobs", jobs_done, 4);
        checkOutput("zero_paths_no_start", start_count - s0, 0);
        checkOutput("zero_paths_no_restart", restart_count - r0, 0);

        // Timeout: engine never finishes, 8 WAIT cycles then RELEASE
        eng_alive = 1'b0;
        r0 = restart_count;
        applyStimulus(16'd5, 16'd3);
        step(9);
        checkOutput("to_last_wait_restart", gcd_restart, 0);
        checkOutput("to_last_wait_valid", rsp_valid, 0);
        step(1);
        checkOutput("to_restart", gcd_restart, 1);
        checkOutput("to_release_valid", rsp_valid, 0);
        step(1);
        checkOutput("to_valid", rsp_valid, 1);
        checkOutput("to_gcd", rsp_gcd, 0);
        checkOutput("to_err", rsp_err, 1);
        checkOutput("to_restart_off", gcd_restart, 0);
        takeResponse();
        checkOutput("to_jobs", jobs_done, 5);
        checkOutput("to_restart_pulses", restart_count - r0, 1);
        eng_alive = 1'b1;

        // Done arrives on the last WAIT cycle: done beats timeout
        eng_latency = 7;
        applyStimulus(16'd27, 16'd18);
        step(10);
        checkOutput("dw_restart", gcd_restart, 1);
        step(1);
        checkOutput("dw_valid", rsp_valid, 1);
        checkOutput("dw_gcd", rsp_gcd, 9);
        checkOutput("dw_err", rsp_err, 0);
        takeResponse();
        checkOutput("dw_jobs", jobs_done, 6);
        eng_latency = 0;

        // (21,14) with back-pressure; a competing request must be ignored
        applyStimulus(16'd21, 16'd14);
        step(4);
        req_a     = 16'd3;
        req_b     = 16'd3;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", rsp_valid, 1);
            checkOutput("bp_gcd", rsp_gcd, 7);
            checkOutput("bp_err", rsp_err, 0);
            checkOutput("bp_req_ready", req_ready, 0);
            step(1);
        end
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        takeResponse();
        checkOutput("bp_jobs", jobs_done, 7);
        checkOutput("bp_req_ready_back", req_ready, 1);
        step(1);
        checkOutput("bp_no_queued_valid", rsp_valid, 0);
        checkOutput("bp_no_queued_start", gcd_start, 0);

        // Reset during WAIT abandons the job
        eng_latency = 20;
        applyStimulus(16'd100, 16'd75);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mr_req_ready", req_ready, 1);
        checkOutput("mr_rsp_valid", rsp_valid, 0);
        checkOutput("mr_rsp_err", rsp_err, 0);
        checkOutput("mr_rsp_gcd", rsp_gcd, 0);
        checkOutput("mr_gcd_start", gcd_start, 0);
        checkOutput("mr_gcd_restart", gcd_restart, 0);
        checkOutput("mr_gcd_data", gcd_data, 0);
        checkOutput("mr_jobs", jobs_done, 0);
        step(2);
        rst_n       = 1'b1;
        eng_latency = 0;
        step(1);
        checkOutput("mr_no_response", rsp_valid, 0);
        applyStimulus(16'd9, 16'd6);
        checkOutput("mr_j_start", gcd_start, 1);
        checkOutput("mr_j_data_a", gcd_data, 9);
        step(1);
        checkOutput("mr_j_data_b", gcd_data, 6);
        step(3);
        checkOutput("mr_j_valid", rsp_valid, 1);
        checkOutput("mr_j_gcd", rsp_gcd, 3);
        checkOutput("mr_j_err", rsp_err, 0);
        takeResponse();
        checkOutput("mr_j_jobs", jobs_done, 1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
